// File: rtl/seek_z.sv
// Radix-2 shift-add multiplier feeding the seek_r reduction stage.
// Produces z = a*b over DW+1 cycles and presents f/z/d with a one-cycle en pulse.
`ifndef Datawidth
`define Datawidth 31
`endif

module seek_z #(
    parameter int DW = `Datawidth
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW:0]     a,
    input  logic [DW:0]     b,
    input  logic [DW+2:0]   f_in,
    input  logic [DW+1:0]   d_in,
    output logic            busy,
    output logic [DW+2:0]   f,
    output logic [2*DW+1:0] z,
    output logic [DW+1:0]   d,
    output logic            en
);

    localparam int ZW = 2*DW + 2;
    localparam int CW = (DW + 1 > 1) ? $clog2(DW + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [ZW-1:0]   a_sh;
    logic [DW:0]     b_sh;
    logic [ZW-1:0]   acc;
    logic [ZW-1:0]   acc_next;
    logic [CW-1:0]   cnt;
    logic [DW+2:0]   f_cap;
    logic [DW+1:0]   d_cap;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (b_sh[0])
            acc_next = acc + a_sh;
    end

    assign busy = (state == RUN);

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: every register here is plain flops (no memory array), so all are reset to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            f_cap <= '0;
            d_cap <= '0;
            f     <= '0;
            z     <= '0;
            d     <= '0;
            en    <= 1'b0;
        end else begin
            en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= {{(DW+1){1'b0}}, a};
                        b_sh  <= b;
                        f_cap <= f_in;
                        d_cap <= d_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    // Last iteration: publish the sum including this cycle's partial product.
                    if (cnt == CW'(DW)) begin
                        z     <= acc_next;
                        f     <= f_cap;
                        d     <= d_cap;
                        en    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seek_z.sv
// Scoreboard bench for seek_z: a cycle-level reference predicts accepts, latency and f/z/d;
// a negedge monitor compares every cycle against it.
module tb_seek_z;

    localparam int DW = 31;
    localparam int ZW = 2*DW + 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [DW:0]     a = '0;
    logic [DW:0]     b = '0;
    logic [DW+2:0]   f_in = '0;
    logic [DW+1:0]   d_in = '0;
    logic            busy;
    logic [DW+2:0]   f;
    logic [ZW-1:0]   z;
    logic [DW+1:0]   d;
    logic            en;

    seek_z #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .f_in  (f_in),
        .d_in  (d_in),
        .busy  (busy),
        .f     (f),
        .z     (z),
        .d     (d),
        .en    (en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW+2:0] f;
        logic [ZW-1:0] z;
        logic [DW+1:0] d;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   next_free = 0;
    int   cur_due = -1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [DW+2:0] hold_f = '0;
    logic [ZW-1:0] hold_z = '0;
    logic [DW+1:0] hold_d = '0;
    bit   mon_on = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: one product per accept, accepted only when the previous one has finished.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            next_free = 0;
            cur_due   = -1;
            hold_f    = '0;
            hold_z    = '0;
            hold_d    = '0;
        end else begin
            cyc++;
            if (start && cyc >= next_free) begin
                exp_t e;
                e.f   = f_in;
                e.z   = ZW'(a) * ZW'(b);
                e.d   = d_in;
                e.due = cyc + DW + 1;
                exp_q.push_back(e);
                cur_due   = cyc + DW + 1;
                next_free = cyc + DW + 2;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (!reset) begin
                check("reset_busy", 128'(busy), 128'(0));
                check("reset_en",   128'(en),   128'(0));
                check("reset_f",    128'(f),    128'(0));
                check("reset_z",    128'(z),    128'(0));
                check("reset_d",    128'(d),    128'(0));
            end else begin
                bit exp_en;
                exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                check("busy", 128'(busy), 128'(cyc < cur_due));
                check("en",   128'(en),   128'(exp_en));
                if (exp_en) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    hold_f = e.f;
                    hold_z = e.z;
                    hold_d = e.d;
                end
                check("f_out", 128'(f), 128'(hold_f));
                check("z_out", 128'(z), 128'(hold_z));
                check("d_out", 128'(d), 128'(hold_d));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_ops(input logic [DW:0] av, input logic [DW:0] bv,
                           input logic [DW+2:0] fv, input logic [DW+1:0] dv);
        a    = av;
        b    = bv;
        f_in = fv;
        d_in = dv;
    endtask

    task automatic one_shot(input logic [DW:0] av, input logic [DW:0] bv,
                            input logic [DW+2:0] fv, input logic [DW+1:0] dv);
        set_ops(av, bv, fv, dv);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset held with start requested: outputs must stay zero.
        reset = 1'b0;
        start = 1'b1;
        set_ops(3, 5, 7, 2);
        step(6);
        reset = 1'b1;
        step(1);
        start = 1'b0;
        step(40);

        // Maximum operands and a zero multiplicand.
        one_shot('1, '1, 35'h1_2345_6789, 33'h1_ABCD_0123);
        step(40);
        one_shot('0, '1, 35'h7_FFFF_FFFF, 33'h1_FFFF_FFFF);
        step(40);

        // Second start during RUN must be ignored.
        one_shot(11, 13, 1, 1);
        step(9);
        one_shot(9, 9, 99, 99);
        step(40);

        // Start held high: back-to-back products.
        set_ops(2, 3, 10, 20);
        start = 1'b1;
        step(1);
        set_ops(4, 5, 30, 40);
        step(40);
        start = 1'b0;
        step(40);

        // Reset mid-product, then a fresh product.
        one_shot(100, 200, 5, 6);
        step(14);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        one_shot(6, 7, 8, 9);
        step(40);

        // Randomized traffic with occasional reset pulses and corner operands.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            reset = ($urandom_range(0, 399) != 0);
            start = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? '0 : (sel == 1) ? '1 : DW'($urandom);
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? '0 : (sel == 1) ? '1 : DW'($urandom);
            f_in = {3'($urandom_range(0, 7)), 32'($urandom)};
            d_in = {1'($urandom_range(0, 1)), 32'($urandom)};
            step(1);
        end
        reset = 1'b1;
        start = 1'b0;
        step(40);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
